// File: rtl/hazard_pkg.sv
// Shared types and constants for the register scoreboard and issue controller.
package hazard_pkg;

    localparam int REG_ADDR_W        = 5;
    localparam int MAX_INFLIGHT_DFLT = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Width of a per-register in-flight counter able to hold 0..max_inflight.
    function automatic int count_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    localparam int CNT_W = count_width(MAX_INFLIGHT_DFLT);

endpackage

// File: rtl/sb_counter_array.sv
// Per-register in-flight write counters with same-register inc/dec cancellation
// and a sticky error flag for retires that would underflow a counter.
module sb_counter_array
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CW       = CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inc,
    input  logic [REG_ADDR_W-1:0]          inc_addr,
    input  logic                           dec,
    input  logic [REG_ADDR_W-1:0]          dec_addr,
    output logic [NUM_REGS-1:0][CW-1:0]    count,
    output logic [NUM_REGS-1:0]            busy_mask,
    output logic                           sb_error
);

    logic [NUM_REGS-1:0][CW-1:0] count_r;
    logic [NUM_REGS-1:0][CW-1:0] count_next_s;
    logic [NUM_REGS-1:0]         busy_r;
    logic [NUM_REGS-1:0]         busy_next_s;
    logic                        err_r;
    logic                        underflow_s;

    // Next-count computation; register 0 is never tracked.
    always_comb begin
        count_next_s = count_r;
        busy_next_s  = {NUM_REGS{1'b0}};
        underflow_s  = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (inc && (inc_addr == REG_ADDR_W'(i)) &&
                !(dec && (dec_addr == REG_ADDR_W'(i)))) begin
                count_next_s[i] = count_r[i] + CW'(1);
            end else if (dec && (dec_addr == REG_ADDR_W'(i)) &&
                         !(inc && (inc_addr == REG_ADDR_W'(i)))) begin
                if (count_r[i] == {CW{1'b0}}) begin
                    underflow_s = 1'b1;
                end else begin
                    count_next_s[i] = count_r[i] - CW'(1);
                end
            end else begin
                count_next_s[i] = count_r[i];
            end
            busy_next_s[i] = (count_next_s[i] != {CW{1'b0}});
        end
        count_next_s[0] = {CW{1'b0}};
    end

    // Counter, busy mask and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {(NUM_REGS*CW){1'b0}};
            busy_r  <= {NUM_REGS{1'b0}};
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            busy_r  <= busy_next_s;
            err_r   <= err_r | underflow_s;
        end
    end

    assign count     = count_r;
    assign busy_mask = busy_r;
    assign sb_error  = err_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue controller for the in-order pipeline: RAW/WAW-capacity stall decision,
// halt drain sequencing and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DFLT,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_w_enable,
    input  logic                  id_is_halt,
    input  logic                  wb_w_enable,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic                  issue,
    output logic                  stall,
    output logic                  fetch_enable,
    output logic                  halted,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [31:0]           stall_cycles,
    output logic                  sb_error
);

    localparam int CW = count_width(MAX_INFLIGHT);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = {REG_ADDR_W{1'b0}};

    logic [NUM_REGS-1:0][CW-1:0] count_s;
    logic raw1_s, raw2_s, waw_full_s, issue_s, stall_s, inc_s, dec_s;

    state_e        state_r, state_next_s;
    logic [DW-1:0] drain_r, drain_next_s;
    logic          fetch_enable_r, fetch_next_s;
    logic          halted_r, halted_next_s;
    logic [31:0]   stall_cycles_r, stall_next_s;

    // Hazards are judged only against registered counts, so a retire never bypasses into issue.
    assign raw1_s     = id_rs1_used && (id_rs1_addr != ZERO_ADDR) &&
                        (count_s[id_rs1_addr] != {CW{1'b0}});
    assign raw2_s     = id_rs2_used && (id_rs2_addr != ZERO_ADDR) &&
                        (count_s[id_rs2_addr] != {CW{1'b0}});
    assign waw_full_s = id_w_enable && (id_rd_addr != ZERO_ADDR) &&
                        (count_s[id_rd_addr] == CW'(MAX_INFLIGHT));
    assign issue_s    = id_valid && (state_r == RUN) && !raw1_s && !raw2_s && !waw_full_s;
    assign stall_s    = id_valid && !issue_s;
    assign inc_s      = issue_s && id_w_enable && (id_rd_addr != ZERO_ADDR);
    assign dec_s      = wb_w_enable && (wb_rd_addr != ZERO_ADDR);

    sb_counter_array #(
        .NUM_REGS (NUM_REGS),
        .CW       (CW)
    ) u_counters (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_s),
        .inc_addr  (id_rd_addr),
        .dec       (dec_s),
        .dec_addr  (wb_rd_addr),
        .count     (count_s),
        .busy_mask (busy_mask),
        .sb_error  (sb_error)
    );

    // Run / drain / halted sequencing.
    always_comb begin
        state_next_s  = state_r;
        drain_next_s  = drain_r;
        fetch_next_s  = fetch_enable_r;
        halted_next_s = halted_r;
        case (state_r)
            RUN: begin
                if (issue_s && id_is_halt) begin
                    state_next_s = DRAIN;
                    drain_next_s = DW'(DRAIN_CYCLES);
                    fetch_next_s = 1'b0;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_r != {DW{1'b0}}) begin
                    drain_next_s = drain_r - DW'(1);
                end else if (busy_mask == {NUM_REGS{1'b0}}) begin
                    state_next_s  = HALTED;
                    halted_next_s = 1'b1;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HALTED: begin
                fetch_next_s  = 1'b0;
                halted_next_s = 1'b1;
            end
            default: begin
                state_next_s  = RUN;
                drain_next_s  = {DW{1'b0}};
                fetch_next_s  = 1'b1;
                halted_next_s = 1'b0;
            end
        endcase
    end

    // Stall counter only counts decode stalls while running, saturating at all-ones.
    always_comb begin
        if ((state_r == RUN) && stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_next_s = stall_cycles_r + 32'd1;
        end else begin
            stall_next_s = stall_cycles_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RUN;
            drain_r        <= {DW{1'b0}};
            fetch_enable_r <= 1'b1;
            halted_r       <= 1'b0;
            stall_cycles_r <= 32'd0;
        end else begin
            state_r        <= state_next_s;
            drain_r        <= drain_next_s;
            fetch_enable_r <= fetch_next_s;
            halted_r       <= halted_next_s;
            stall_cycles_r <= stall_next_s;
        end
    end

    assign issue        = issue_s;
    assign stall        = stall_s;
    assign fetch_enable = fetch_enable_r;
    assign halted       = halted_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a per-register pending-write reference model.
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int MI = 3;
    localparam int DC = 3;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_rs1_used, id_rs2_used, id_w_enable, id_is_halt, wb_w_enable;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
    logic        issue, stall, fetch_enable, halted, sb_error;
    logic [NR-1:0] busy_mask;
    logic [31:0] stall_cycles;

    hazard_scoreboard #(.NUM_REGS(NR), .MAX_INFLIGHT(MI), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_w_enable(id_w_enable), .id_is_halt(id_is_halt),
        .wb_w_enable(wb_w_enable), .wb_rd_addr(wb_rd_addr),
        .issue(issue), .stall(stall), .fetch_enable(fetch_enable), .halted(halted),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles), .sb_error(sb_error)
    );

    typedef struct {
        logic          issue, stall, fetch, halted, err;
        logic [NR-1:0] busy;
        logic [31:0]   sc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: pending write count per register plus control state.
    int          m_cnt[NR];
    int          m_mode, m_drain;
    bit          m_fetch, m_halted, m_err;
    logic [31:0] m_sc;

    function automatic void model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_mode = M_RUN; m_drain = 0; m_fetch = 1'b1; m_halted = 1'b0; m_err = 1'b0; m_sc = 32'd0;
    endfunction

    function automatic bit model_issue();
        if (!id_valid || m_mode != M_RUN) return 1'b0;
        if (id_rs1_used && id_rs1_addr != 5'd0 && m_cnt[id_rs1_addr] > 0) return 1'b0;
        if (id_rs2_used && id_rs2_addr != 5'd0 && m_cnt[id_rs2_addr] > 0) return 1'b0;
        if (id_w_enable && id_rd_addr != 5'd0 && m_cnt[id_rd_addr] >= MI) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(input bit r, input bit iss);
        bit all_idle, inc, dec;
        if (r) begin
            model_reset();
            return;
        end
        all_idle = 1'b1;
        foreach (m_cnt[i]) if (m_cnt[i] > 0) all_idle = 1'b0;
        inc = iss && id_w_enable && id_rd_addr != 5'd0;
        dec = wb_w_enable && wb_rd_addr != 5'd0;
        if (!(inc && dec && id_rd_addr == wb_rd_addr)) begin
            if (inc) m_cnt[id_rd_addr]++;
            if (dec) begin
                if (m_cnt[wb_rd_addr] == 0) m_err = 1'b1;
                else m_cnt[wb_rd_addr]--;
            end
        end
        if (m_mode == M_RUN && id_valid && !iss && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        if (m_mode == M_RUN) begin
            if (iss && id_is_halt) begin
                m_mode = M_DRAIN; m_drain = DC; m_fetch = 1'b0;
            end
        end else if (m_mode == M_DRAIN) begin
            if (m_drain > 0) m_drain--;
            else if (all_idle) begin
                m_mode = M_HALTED; m_halted = 1'b1;
            end
        end
    endfunction

    // One cycle of stimulus: drive, record the expected response, advance the model.
    task automatic step(input bit r, input bit v, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                        input bit we, input bit hlt, input bit wbe, input logic [4:0] wbr);
        exp_t e;
        bit   iss;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2; id_rd_addr = rd; id_w_enable = we;
        id_is_halt = hlt; wb_w_enable = wbe; wb_rd_addr = wbr;
        iss = model_issue();
        e.issue = iss; e.stall = id_valid && !iss;
        e.fetch = m_fetch; e.halted = m_halted; e.err = m_err; e.sc = m_sc;
        for (int i = 0; i < NR; i++) e.busy[i] = (m_cnt[i] > 0);
        exp_q.push_back(e);
        model_edge(r, iss);
    endtask

    task automatic nop(input bit v, input bit wbe, input logic [4:0] wbr);
        step(1'b0, v, 5'd1, v, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, wbe, wbr);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endfunction

    // Monitor: compare every presented cycle against its queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue", 32'(issue), 32'(e.issue));
            chk("stall", 32'(stall), 32'(e.stall));
            chk("fetch_enable", 32'(fetch_enable), 32'(e.fetch));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("sb_error", 32'(sb_error), 32'(e.err));
            chk("busy_mask", busy_mask, e.busy);
            chk("stall_cycles", stall_cycles, e.sc);
        end
    end

    initial begin
        logic [4:0] cand;
        bit         wbe;
        rst = 1'b1; id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_addr = 5'd0; id_w_enable = 1'b0;
        id_is_halt = 1'b0; wb_w_enable = 1'b0; wb_rd_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);

        // Independent ALU ops every cycle.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 2), 1'b1, 5'(i + 10), 1'b0, 1'b0, 1'b0, 5'd0);

        // RAW on x5, retire three cycles later.
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5);
        step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
        nop(1'b0, 1'b1, 5'd6);

        // x0 never blocks; store waits on x7 via rs2.
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // WAW capacity on x9, including same-cycle inc/dec.
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        repeat (3) nop(1'b0, 1'b1, 5'd9);

        // Halt with two writes outstanding, then reset out of HALTED.
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (2) nop(1'b1, 1'b0, 5'd0);
        nop(1'b1, 1'b1, 5'd3);
        repeat (3) nop(1'b1, 1'b0, 5'd0);
        nop(1'b1, 1'b1, 5'd4);
        repeat (3) nop(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0);
        repeat (2) nop(1'b1, 1'b0, 5'd0);

        // Retire to an idle register sets a sticky error.
        nop(1'b0, 1'b1, 5'd12);
        repeat (3) nop(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        nop(1'b0, 1'b0, 5'd0);

        // Random traffic on a small register window.
        for (int n = 0; n < 800; n++) begin
            cand = 5'($urandom_range(1, 7));
            wbe  = (m_cnt[cand] > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            step(($urandom_range(0, 149) == 0) || (m_mode == M_HALTED && $urandom_range(0, 7) == 0),
                 $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, wbe, cand);
        end
        nop(1'b0, 1'b0, 5'd0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
